// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, stage control,
// MEM/WB forwarding sources and the EX-side operands.
interface id_ex_stage_if #(
  parameter int WIDTH_DATA_LENGTH   = 32,
  parameter int WIDTH_ALUSEL_LENGTH = 4,
  parameter int WIDTH_REG_ADDR      = 5
);
  localparam int DW = WIDTH_DATA_LENGTH;
  localparam int SW = WIDTH_ALUSEL_LENGTH;
  localparam int AW = WIDTH_REG_ADDR;

  logic          ID_Valid;
  logic [DW-1:0] ID_PC;
  logic [DW-1:0] ID_Rs1Data;
  logic [DW-1:0] ID_Rs2Data;
  logic [DW-1:0] ID_Imm;
  logic [AW-1:0] ID_Rs1Addr;
  logic [AW-1:0] ID_Rs2Addr;
  logic [AW-1:0] ID_RdAddr;
  logic          ID_UsesRs1;
  logic          ID_UsesRs2;
  logic [SW-1:0] ID_ALUSel;
  logic          ID_ASel;
  logic          ID_BSel;
  logic          ID_RegWEn;
  logic          ID_MemRead;
  logic          ID_MemWrite;

  logic          Stall;
  logic          Flush;

  logic          MEM_Valid;
  logic          MEM_RegWEn;
  logic [AW-1:0] MEM_RdAddr;
  logic [DW-1:0] MEM_ALUResult;

  logic          WB_Valid;
  logic          WB_RegWEn;
  logic [AW-1:0] WB_RdAddr;
  logic [DW-1:0] WB_Data;

  logic [DW-1:0] DataA;
  logic [DW-1:0] DataB;
  logic [SW-1:0] ALUSel;
  logic [DW-1:0] StoreData;
  logic [DW-1:0] EX_PC;
  logic [AW-1:0] EX_RdAddr;
  logic          EX_Valid;
  logic          EX_RegWEn;
  logic          EX_MemRead;
  logic          EX_MemWrite;
  logic          LoadUseHazard;

  modport master (
    output ID_Valid, ID_PC,
    output ID_Rs1Data, ID_Rs2Data, ID_Imm,
    output ID_Rs1Addr, ID_Rs2Addr, ID_RdAddr,
    output ID_UsesRs1, ID_UsesRs2,
    output ID_ALUSel, ID_ASel, ID_BSel,
    output ID_RegWEn, ID_MemRead, ID_MemWrite,
    output Stall, Flush,
    output MEM_Valid, MEM_RegWEn,
    output MEM_RdAddr, MEM_ALUResult,
    output WB_Valid, WB_RegWEn,
    output WB_RdAddr, WB_Data,
    input  DataA, DataB, ALUSel, StoreData,
    input  EX_PC, EX_RdAddr, EX_Valid,
    input  EX_RegWEn, EX_MemRead, EX_MemWrite,
    input  LoadUseHazard
  );

  modport slave (
    input  ID_Valid, ID_PC,
    input  ID_Rs1Data, ID_Rs2Data, ID_Imm,
    input  ID_Rs1Addr, ID_Rs2Addr, ID_RdAddr,
    input  ID_UsesRs1, ID_UsesRs2,
    input  ID_ALUSel, ID_ASel, ID_BSel,
    input  ID_RegWEn, ID_MemRead, ID_MemWrite,
    input  Stall, Flush,
    input  MEM_Valid, MEM_RegWEn,
    input  MEM_RdAddr, MEM_ALUResult,
    input  WB_Valid, WB_RegWEn,
    input  WB_RdAddr, WB_Data,
    output DataA, DataB, ALUSel, StoreData,
    output EX_PC, EX_RdAddr, EX_Valid,
    output EX_RegWEn, EX_MemRead, EX_MemWrite,
    output LoadUseHazard
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding,
// load-use bubble insertion and stall/flush control.
module id_ex_stage #(
  parameter int WIDTH_DATA_LENGTH   = 32,
  parameter int WIDTH_ALUSEL_LENGTH = 4,
  parameter int WIDTH_REG_ADDR      = 5
) (
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.slave  bus
);
  localparam int DW = WIDTH_DATA_LENGTH;
  localparam int SW = WIDTH_ALUSEL_LENGTH;
  localparam int AW = WIDTH_REG_ADDR;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs1data;
    logic [DW-1:0] rs2data;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs1addr;
    logic [AW-1:0] rs2addr;
    logic [AW-1:0] rdaddr;
    logic [SW-1:0] alusel;
    logic          asel;
    logic          bsel;
    logic          regwen;
    logic          memread;
    logic          memwrite;
  } ex_t;

  ex_t ex;
  ex_t cap;

  logic          mem_hit1, mem_hit2;
  logic          wb_hit1, wb_hit2;
  logic          wt1, wt2;
  logic [DW-1:0] rs1fwd, rs2fwd;
  logic          dep1, dep2;
  logic          luh;

  function automatic logic hit(
    input logic          v,
    input logic          we,
    input logic [AW-1:0] rd,
    input logic [AW-1:0] rs
  );
    return v & we & (rd != '0) & (rd == rs);
  endfunction

  assign mem_hit1 = hit(bus.MEM_Valid,
                        bus.MEM_RegWEn,
                        bus.MEM_RdAddr,
                        ex.rs1addr);
  assign mem_hit2 = hit(bus.MEM_Valid,
                        bus.MEM_RegWEn,
                        bus.MEM_RdAddr,
                        ex.rs2addr);
  assign wb_hit1  = hit(bus.WB_Valid,
                        bus.WB_RegWEn,
                        bus.WB_RdAddr,
                        ex.rs1addr);
  assign wb_hit2  = hit(bus.WB_Valid,
                        bus.WB_RegWEn,
                        bus.WB_RdAddr,
                        ex.rs2addr);

  // Same-cycle RF write/read: WB data bypasses the ID read.
  assign wt1 = hit(bus.WB_Valid,
                   bus.WB_RegWEn,
                   bus.WB_RdAddr,
                   bus.ID_Rs1Addr);
  assign wt2 = hit(bus.WB_Valid,
                   bus.WB_RegWEn,
                   bus.WB_RdAddr,
                   bus.ID_Rs2Addr);

  always_comb begin
    rs1fwd = ex.rs1data;
    if (mem_hit1)
      rs1fwd = bus.MEM_ALUResult;
    else if (wb_hit1)
      rs1fwd = bus.WB_Data;
  end

  always_comb begin
    rs2fwd = ex.rs2data;
    if (mem_hit2)
      rs2fwd = bus.MEM_ALUResult;
    else if (wb_hit2)
      rs2fwd = bus.WB_Data;
  end

  assign dep1 = bus.ID_UsesRs1 &
                (bus.ID_Rs1Addr == ex.rdaddr);
  assign dep2 = bus.ID_UsesRs2 &
                (bus.ID_Rs2Addr == ex.rdaddr);

  assign luh = ~bus.Flush
             & bus.ID_Valid
             & ex.valid
             & ex.memread
             & (ex.rdaddr != '0)
             & (dep1 | dep2);

  always_comb begin
    cap          = '0;
    cap.valid    = bus.ID_Valid;
    cap.pc       = bus.ID_PC;
    cap.rs1data  = wt1 ? bus.WB_Data
                       : bus.ID_Rs1Data;
    cap.rs2data  = wt2 ? bus.WB_Data
                       : bus.ID_Rs2Data;
    cap.imm      = bus.ID_Imm;
    cap.rs1addr  = bus.ID_Rs1Addr;
    cap.rs2addr  = bus.ID_Rs2Addr;
    cap.rdaddr   = bus.ID_RdAddr;
    cap.alusel   = bus.ID_ALUSel;
    cap.asel     = bus.ID_ASel;
    cap.bsel     = bus.ID_BSel;
    cap.regwen   = bus.ID_RegWEn;
    cap.memread  = bus.ID_MemRead;
    cap.memwrite = bus.ID_MemWrite;
  end

  // A held instruction refreshes its operands so a
  // producer retiring from WB mid-stall is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex <= '0;
    end else if (bus.Flush) begin
      ex.valid    <= 1'b0;
      ex.regwen   <= 1'b0;
      ex.memread  <= 1'b0;
      ex.memwrite <= 1'b0;
    end else if (bus.Stall) begin
      ex.rs1data  <= rs1fwd;
      ex.rs2data  <= rs2fwd;
    end else if (luh) begin
      ex.valid    <= 1'b0;
      ex.regwen   <= 1'b0;
      ex.memread  <= 1'b0;
      ex.memwrite <= 1'b0;
    end else begin
      ex <= cap;
    end
  end

  assign bus.DataA = ex.asel ? ex.pc : rs1fwd;
  assign bus.DataB = ex.bsel ? ex.imm : rs2fwd;
  assign bus.StoreData     = rs2fwd;
  assign bus.ALUSel        = ex.alusel;
  assign bus.EX_PC         = ex.pc;
  assign bus.EX_RdAddr     = ex.rdaddr;
  assign bus.EX_Valid      = ex.valid;
  assign bus.EX_RegWEn     = ex.regwen;
  assign bus.EX_MemRead    = ex.memread;
  assign bus.EX_MemWrite   = ex.memwrite;
  assign bus.LoadUseHazard = luh;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random checks of id_ex_stage against
// an instruction-level reference model.
module tb_id_ex_stage;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  a1, a2, rd;
    logic [3:0]  alu;
    bit          asel, bsel, we, mr, mw;
  } instr_t;

  instr_t m;

  function automatic instr_t empty();
    instr_t e;
    e.v = 0; e.pc = '0; e.r1 = '0;
    e.r2 = '0; e.imm = '0; e.a1 = '0;
    e.a2 = '0; e.rd = '0; e.alu = '0;
    e.asel = 0; e.bsel = 0; e.we = 0;
    e.mr = 0; e.mw = 0;
    return e;
  endfunction

  function automatic bit writes(
    input logic v, we,
    input logic [4:0] rd, r
  );
    return v && we && rd != 0 && rd == r;
  endfunction

  // Newest value of register r as seen by EX.
  function automatic logic [31:0] newest(
    input logic [4:0] r,
    input logic [31:0] held
  );
    if (writes(bus.MEM_Valid, bus.MEM_RegWEn,
               bus.MEM_RdAddr, r))
      return bus.MEM_ALUResult;
    if (writes(bus.WB_Valid, bus.WB_RegWEn,
               bus.WB_RdAddr, r))
      return bus.WB_Data;
    return held;
  endfunction

  function automatic bit exp_luh();
    bit dep;
    dep = (bus.ID_UsesRs1 && bus.ID_Rs1Addr == m.rd)
       || (bus.ID_UsesRs2 && bus.ID_Rs2Addr == m.rd);
    return !bus.Flush && bus.ID_Valid && m.v
        && m.mr && m.rd != 0 && dep;
  endfunction

  function automatic instr_t next_ex();
    instr_t n;
    n = m;
    if (rst) begin
      n = empty();
    end else if (bus.Flush || (!bus.Stall && exp_luh())) begin
      n.v = 0; n.we = 0; n.mr = 0; n.mw = 0;
    end else if (bus.Stall) begin
      n.r1 = newest(m.a1, m.r1);
      n.r2 = newest(m.a2, m.r2);
    end else begin
      n.v    = bus.ID_Valid;
      n.pc   = bus.ID_PC;
      n.imm  = bus.ID_Imm;
      n.a1   = bus.ID_Rs1Addr;
      n.a2   = bus.ID_Rs2Addr;
      n.rd   = bus.ID_RdAddr;
      n.alu  = bus.ID_ALUSel;
      n.asel = bus.ID_ASel;
      n.bsel = bus.ID_BSel;
      n.we   = bus.ID_RegWEn;
      n.mr   = bus.ID_MemRead;
      n.mw   = bus.ID_MemWrite;
      n.r1 = writes(bus.WB_Valid, bus.WB_RegWEn,
                    bus.WB_RdAddr, bus.ID_Rs1Addr)
           ? bus.WB_Data : bus.ID_Rs1Data;
      n.r2 = writes(bus.WB_Valid, bus.WB_RegWEn,
                    bus.WB_RdAddr, bus.ID_Rs2Addr)
           ? bus.WB_Data : bus.ID_Rs2Data;
    end
    return n;
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] f1, f2;
    f1 = newest(m.a1, m.r1);
    f2 = newest(m.a2, m.r2);
    chk("DataA", bus.DataA, m.asel ? m.pc : f1);
    chk("DataB", bus.DataB, m.bsel ? m.imm : f2);
    chk("StoreData", bus.StoreData, f2);
    chk("ALUSel", 32'(bus.ALUSel), 32'(m.alu));
    chk("EX_PC", bus.EX_PC, m.pc);
    chk("EX_RdAddr", 32'(bus.EX_RdAddr), 32'(m.rd));
    chk("EX_Valid", 32'(bus.EX_Valid), 32'(m.v));
    chk("EX_RegWEn", 32'(bus.EX_RegWEn), 32'(m.we));
    chk("EX_MemRead", 32'(bus.EX_MemRead), 32'(m.mr));
    chk("EX_MemWrite", 32'(bus.EX_MemWrite),
        32'(m.mw));
    chk("LoadUseHazard", 32'(bus.LoadUseHazard),
        32'(exp_luh()));
  endtask

  task automatic tick();
    instr_t n;
    #1;
    check_model();
    n = next_ex();
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic idle();
    rst = 0;
    bus.ID_Valid = 0; bus.ID_PC = '0;
    bus.ID_Rs1Data = '0; bus.ID_Rs2Data = '0;
    bus.ID_Imm = '0; bus.ID_Rs1Addr = '0;
    bus.ID_Rs2Addr = '0; bus.ID_RdAddr = '0;
    bus.ID_UsesRs1 = 0; bus.ID_UsesRs2 = 0;
    bus.ID_ALUSel = '0; bus.ID_ASel = 0;
    bus.ID_BSel = 0; bus.ID_RegWEn = 0;
    bus.ID_MemRead = 0; bus.ID_MemWrite = 0;
    bus.Stall = 0; bus.Flush = 0;
    bus.MEM_Valid = 0; bus.MEM_RegWEn = 0;
    bus.MEM_RdAddr = '0; bus.MEM_ALUResult = '0;
    bus.WB_Valid = 0; bus.WB_RegWEn = 0;
    bus.WB_RdAddr = '0; bus.WB_Data = '0;
  endtask

  task automatic id_set(
    input logic [31:0] pc, d1, d2, imm,
    input logic [4:0]  a1, a2, rd,
    input logic u1, u2,
    input logic [3:0] alu,
    input logic as, bs, we, mr, mw
  );
    bus.ID_Valid = 1; bus.ID_PC = pc;
    bus.ID_Rs1Data = d1; bus.ID_Rs2Data = d2;
    bus.ID_Imm = imm; bus.ID_Rs1Addr = a1;
    bus.ID_Rs2Addr = a2; bus.ID_RdAddr = rd;
    bus.ID_UsesRs1 = u1; bus.ID_UsesRs2 = u2;
    bus.ID_ALUSel = alu; bus.ID_ASel = as;
    bus.ID_BSel = bs; bus.ID_RegWEn = we;
    bus.ID_MemRead = mr; bus.ID_MemWrite = mw;
  endtask

  task automatic set_wb(
    input logic [4:0] rd,
    input logic [31:0] d
  );
    bus.WB_Valid = 1; bus.WB_RegWEn = 1;
    bus.WB_RdAddr = rd; bus.WB_Data = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    m = empty();
    tick();

    // reset mid-stream
    idle();
    id_set(32'h20, 1, 2, 3, 1, 2, 3, 1, 1,
           4'h5, 0, 0, 1, 0, 0);
    tick();
    chk("pre_rst_valid", 32'(bus.EX_Valid), 1);
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst_valid", 32'(bus.EX_Valid), 0);
    chk("rst_alusel", 32'(bus.ALUSel), 0);
    chk("rst_dataa", bus.DataA, 0);
    chk("rst_datab", bus.DataB, 0);
    tick();
    chk("post_rst_cap", 32'(bus.EX_Valid), 1);
    chk("post_rst_pc", bus.EX_PC, 32'h20);

    // MEM beats WB
    idle();
    id_set(32'h40, 5, 7, 0, 1, 2, 3, 1, 1,
           4'h0, 0, 0, 1, 0, 0);
    tick();
    idle();
    bus.MEM_Valid = 1; bus.MEM_RegWEn = 1;
    bus.MEM_RdAddr = 1; bus.MEM_ALUResult = 32'h10;
    #2;
    chk("mem_fwd_a", bus.DataA, 32'h10);
    chk("plain_b", bus.DataB, 32'h7);
    set_wb(1, 32'h20);
    #1;
    chk("mem_over_wb", bus.DataA, 32'h10);
    tick();

    // load-use bubble then WB forward
    idle();
    id_set(32'h50, 0, 0, 8, 2, 0, 4, 1, 0,
           4'h0, 0, 1, 1, 1, 0);
    tick();
    id_set(32'h54, 0, 0, 0, 4, 4, 5, 1, 1,
           4'h0, 0, 0, 1, 0, 0);
    #2;
    chk("luh_on", 32'(bus.LoadUseHazard), 1);
    tick();
    chk("bubble", 32'(bus.EX_Valid), 0);
    #1;
    chk("luh_once", 32'(bus.LoadUseHazard), 0);
    tick();
    idle();
    set_wb(4, 32'hDEADBEEF);
    #2;
    chk("add_in", bus.EX_PC, 32'h54);
    chk("wb_fwd_a", bus.DataA, 32'hDEADBEEF);
    chk("wb_fwd_b", bus.DataB, 32'hDEADBEEF);
    tick();

    // x0 never forwarded
    idle();
    id_set(32'h60, 0, 0, 0, 0, 0, 6, 1, 0,
           4'h0, 0, 0, 1, 0, 0);
    tick();
    idle();
    bus.MEM_Valid = 1; bus.MEM_RegWEn = 1;
    bus.MEM_RdAddr = 0; bus.MEM_ALUResult = 32'h55;
    #2;
    chk("x0_nofwd", bus.DataA, 0);
    tick();
    idle();
    id_set(32'h64, 0, 0, 0, 1, 0, 0, 1, 0,
           4'h0, 0, 1, 1, 1, 0);
    tick();
    id_set(32'h68, 0, 0, 0, 0, 0, 7, 1, 0,
           4'h0, 0, 0, 1, 0, 0);
    #2;
    chk("x0_noluh", 32'(bus.LoadUseHazard), 0);
    tick();

    // stall with WB retire in first stall cycle
    idle();
    id_set(32'h70, 1, 32'h11, 4, 1, 6, 0, 1, 1,
           4'h0, 0, 1, 0, 0, 1);
    tick();
    id_set(32'h74, 9, 9, 9, 3, 3, 3, 1, 1,
           4'h2, 1, 0, 1, 0, 0);
    bus.Stall = 1;
    set_wb(6, 32'hAB);
    tick();
    bus.WB_Valid = 0;
    tick();
    tick();
    bus.Stall = 0;
    #2;
    chk("stall_store", bus.StoreData, 32'hAB);
    chk("stall_pc", bus.EX_PC, 32'h70);
    chk("stall_mw", 32'(bus.EX_MemWrite), 1);
    chk("stall_b", bus.DataB, 32'h4);
    tick();

    // flush beats stall, then PC/imm operands
    idle();
    id_set(32'h80, 0, 0, 0, 1, 0, 7, 1, 0,
           4'h0, 0, 1, 1, 1, 0);
    tick();
    id_set(32'h84, 0, 0, 0, 7, 0, 8, 1, 0,
           4'h0, 0, 1, 1, 1, 0);
    bus.Flush = 1;
    bus.Stall = 1;
    #2;
    chk("flush_noluh", 32'(bus.LoadUseHazard), 0);
    tick();
    chk("flush_valid", 32'(bus.EX_Valid), 0);
    chk("flush_mr", 32'(bus.EX_MemRead), 0);
    idle();
    id_set(32'h100, 0, 0, 32'hFFFFFFFC, 0, 0, 9,
           0, 0, 4'h0, 1, 1, 1, 0, 0);
    tick();
    chk("pc_a", bus.DataA, 32'h100);
    chk("imm_b", bus.DataB, 32'hFFFFFFFC);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.Flush = ($urandom_range(0, 9) == 0);
      bus.Stall = ($urandom_range(0, 7) == 0);
      bus.ID_Valid = 1'($urandom_range(0, 3) != 0);
      bus.ID_PC = $urandom;
      bus.ID_Rs1Data = $urandom;
      bus.ID_Rs2Data = $urandom;
      bus.ID_Imm = $urandom;
      bus.ID_Rs1Addr = 5'($urandom_range(0, 3));
      bus.ID_Rs2Addr = 5'($urandom_range(0, 3));
      bus.ID_RdAddr = 5'($urandom_range(0, 3));
      bus.ID_UsesRs1 = 1'($urandom_range(0, 1));
      bus.ID_UsesRs2 = 1'($urandom_range(0, 1));
      bus.ID_ALUSel = 4'($urandom_range(0, 15));
      bus.ID_ASel = 1'($urandom_range(0, 1));
      bus.ID_BSel = 1'($urandom_range(0, 1));
      bus.ID_RegWEn = 1'($urandom_range(0, 1));
      bus.ID_MemRead = 1'($urandom_range(0, 1));
      bus.ID_MemWrite = 1'($urandom_range(0, 1));
      bus.MEM_Valid = 1'($urandom_range(0, 1));
      bus.MEM_RegWEn = 1'($urandom_range(0, 1));
      bus.MEM_RdAddr = 5'($urandom_range(0, 3));
      bus.MEM_ALUResult = $urandom;
      bus.WB_Valid = 1'($urandom_range(0, 1));
      bus.WB_RegWEn = 1'($urandom_range(0, 1));
      bus.WB_RdAddr = 5'($urandom_range(0, 3));
      bus.WB_Data = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
